parking_slot_manager: RTL and testbench
=======================================

Name: parking_slot_manager

Overview:
Parametrised slot allocator and gate sequencer for the smart parking lot.
- Entry: tracks per-slot occupancy and allocates the lowest-index free slot to each entering car.
- Exit: releases the slot named by the exiting car and drives its one-hot location.
- Gate: holds the gate open for a programmable time per transaction.
- Sits between the entry/exit request logic and the lot's location indicators and gate actuator.

Parameters:
NUM_SLOTS, 8, number of parking slots; legal range 2..256.
IDX_W, $clog2(NUM_SLOTS), width of a slot index; derived, never overridden.
GATE_CYCLES, 4, clock cycles the gate stays open per accepted transaction; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
entry_req  input  1  car waiting at the entry; level, sampled each cycle.
exit_req  input  1  car waiting at the exit; level, sampled each cycle.
exit_slot  input  IDX_W  slot number of the exiting car; valid while exit_req=1.
entry_ack  output  1  one-cycle pulse: entry accepted.
entry_slot  output  IDX_W  slot allocated to the last accepted entry.
entry_reject  output  1  one-cycle pulse: entry refused because the lot is full.
exit_ack  output  1  one-cycle pulse: exit accepted.
exit_err  output  1  one-cycle pulse: exit refused (slot free or index >= NUM_SLOTS).
exit_location  output  NUM_SLOTS  one-hot of the released slot; bit k set when slot k is released.
occupancy  output  NUM_SLOTS  bit k = 1 means slot k is occupied.
free_count  output  IDX_W+1  number of free slots.
full  output  1  free_count == 0.
empty  output  1  free_count == NUM_SLOTS.
gate_open  output  1  gate actuator drive.
busy  output  1  high when the FSM is not in IDLE; requests are ignored while busy.

Behaviour:
Reset (rst_n=0, asynchronous):
- state = IDLE; occupancy = 0; free_count = NUM_SLOTS; empty = 1; full = 0.
- All pulses = 0; entry_slot = 0; exit_location = 0; gate_open = 0; gate counter = 0.

Registers and combinational outputs:
- All outputs are registered except busy, full and empty, which decode registered state combinationally.

FSM states:
- IDLE
- ENTRY_OPEN
- EXIT_OPEN

Decisions in IDLE, taken on the rising edge where the request is sampled high:
- Exit has priority when exit_req and entry_req are both high; entry is not evaluated that cycle.
- Valid exit (exit_slot < NUM_SLOTS and occupancy[exit_slot]=1):
  - Clear the occupancy bit; free_count +1.
  - exit_ack = 1 for one cycle.
  - exit_location = one-hot(exit_slot), held until the next exit is accepted or reset.
  - gate_open = 1; state -> EXIT_OPEN.
- Invalid exit: exit_err = 1 for one cycle; no state change; entry is not evaluated that cycle.
- Entry when not full:
  - Allocate the lowest-index slot with occupancy=0; set that bit; free_count -1.
  - entry_slot = allocated index; entry_ack = 1 for one cycle.
  - gate_open = 1; state -> ENTRY_OPEN.
- Entry when full: entry_reject = 1 for one cycle; stay in IDLE.
- Latency: request sampled at edge N; response pulses and occupancy update are visible after edge N.

ENTRY_OPEN / EXIT_OPEN:
- Gate counter loads GATE_CYCLES-1 on entry to the state and decrements each cycle.
- At count 0: gate_open = 0 and state -> IDLE on the same edge.
- gate_open is therefore high for exactly GATE_CYCLES cycles.
- Requests are ignored, not queued; the requester holds its request level.
- A request still high on the first IDLE cycle is evaluated as a new transaction.

Held requests:
- A rejected or erroneous request still high in IDLE re-pulses entry_reject / exit_err every cycle until dropped.

Invariants:
- free_count always equals NUM_SLOTS minus the popcount of occupancy.
- No wrap-around: underflow and overflow are unreachable by construction.

Reset mid-transaction:
- Occupancy is lost (all slots free) and the gate closes immediately.

Test Plan:
1. Fill the lot: reset, NUM_SLOTS=8, GATE_CYCLES=4, hold entry_req=1 -> entry_ack pulses with entry_slot 0,1,...,7, 5 cycles apart; gate_open high 4 cycles each; after the 8th, full=1, free_count=0, then entry_reject pulses every cycle.
2. Release and reuse: occupancy=8'hFF, exit_slot=3 -> exit_ack, exit_location=8'b00001000, occupancy=8'hF7, free_count=1; a following entry gets entry_slot=3.
3. Simultaneous requests: occupancy=8'h01, entry_req and exit_req both 1, exit_slot=0 -> exit served first (occupancy=0, empty=1); after 4 gate cycles the entry gets slot 0.
4. Error cases: exit_slot=5 with occupancy[5]=0 -> exit_err pulse, state IDLE, no gate. With NUM_SLOTS=6, exit_slot=7 -> exit_err.
5. Busy masking: a pulsed entry_req during EXIT_OPEN -> ignored, no entry_ack, occupancy unchanged.
6. Async reset: rst_n low during ENTRY_OPEN, asserted between clock edges -> gate_open, occupancy and state clear immediately without a clock edge.

Source files
------------

// File: rtl/parking_slot_manager.sv
// Parking lot slot allocator and gate sequencer: hands the lowest free slot to
// each entering car, releases slots on exit and holds the gate open per transaction.
module parking_slot_manager #(
  parameter int NUM_SLOTS   = 8,
  parameter int IDX_W       = $clog2(NUM_SLOTS),
  parameter int GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_slot,
  output logic                 entry_ack,
  output logic [IDX_W-1:0]     entry_slot,
  output logic                 entry_reject,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic [NUM_SLOTS-1:0] exit_location,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [IDX_W:0]       free_count,
  output logic                 full,
  output logic                 empty,
  output logic                 gate_open,
  output logic                 busy
);

  localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [IDX_W:0]   SLOTS_CNT = (IDX_W + 1)'(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     gate_cnt_q, gate_cnt_d;
  logic [NUM_SLOTS-1:0] occupancy_q, occupancy_d;
  logic [NUM_SLOTS-1:0] exit_location_q, exit_location_d;
  logic [IDX_W:0]       free_count_q, free_count_d;
  logic [IDX_W-1:0]     entry_slot_q, entry_slot_d;
  logic                 entry_ack_q, entry_ack_d;
  logic                 entry_reject_q, entry_reject_d;
  logic                 exit_ack_q, exit_ack_d;
  logic                 exit_err_q, exit_err_d;
  logic                 gate_open_q, gate_open_d;

  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [NUM_SLOTS-1:0] free_onehot;
  logic                 exit_hit;
  logic [NUM_SLOTS-1:0] exit_onehot;

  // Lowest-index free slot: scanning downward lets the last hit win.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    free_onehot = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!occupancy_q[k]) begin
        free_found     = 1'b1;
        free_idx       = IDX_W'(k);
        free_onehot    = '0;
        free_onehot[k] = 1'b1;
      end else begin
        free_found = free_found;
      end
    end
  end

  // Decode the exit index; an index beyond the last slot matches nothing and is invalid.
  always_comb begin
    exit_hit    = 1'b0;
    exit_onehot = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (exit_slot == IDX_W'(k)) begin
        exit_onehot[k] = 1'b1;
        exit_hit       = occupancy_q[k];
      end else begin
        exit_onehot[k] = 1'b0;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    gate_cnt_d      = gate_cnt_q;
    occupancy_d     = occupancy_q;
    exit_location_d = exit_location_q;
    free_count_d    = free_count_q;
    entry_slot_d    = entry_slot_q;
    gate_open_d     = gate_open_q;
    entry_ack_d     = 1'b0;
    entry_reject_d  = 1'b0;
    exit_ack_d      = 1'b0;
    exit_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (exit_req) begin
          if (exit_hit) begin
            occupancy_d     = occupancy_q & ~exit_onehot;
            free_count_d    = free_count_q + (IDX_W + 1)'(1);
            exit_location_d = exit_onehot;
            exit_ack_d      = 1'b1;
            gate_open_d     = 1'b1;
            gate_cnt_d      = CNT_LOAD;
            state_d         = EXIT_OPEN;
          end else begin
            exit_err_d = 1'b1;
          end
        end else if (entry_req) begin
          if (free_found) begin
            occupancy_d  = occupancy_q | free_onehot;
            free_count_d = free_count_q - (IDX_W + 1)'(1);
            entry_slot_d = free_idx;
            entry_ack_d  = 1'b1;
            gate_open_d  = 1'b1;
            gate_cnt_d   = CNT_LOAD;
            state_d      = ENTRY_OPEN;
          end else begin
            entry_reject_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (gate_cnt_q == '0) begin
          gate_open_d = 1'b0;
          state_d     = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gate_open_d = 1'b0;
        gate_cnt_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gate_cnt_q      <= '0;
      occupancy_q     <= '0;
      exit_location_q <= '0;
      free_count_q    <= SLOTS_CNT;
      entry_slot_q    <= '0;
      entry_ack_q     <= 1'b0;
      entry_reject_q  <= 1'b0;
      exit_ack_q      <= 1'b0;
      exit_err_q      <= 1'b0;
      gate_open_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      gate_cnt_q      <= gate_cnt_d;
      occupancy_q     <= occupancy_d;
      exit_location_q <= exit_location_d;
      free_count_q    <= free_count_d;
      entry_slot_q    <= entry_slot_d;
      entry_ack_q     <= entry_ack_d;
      entry_reject_q  <= entry_reject_d;
      exit_ack_q      <= exit_ack_d;
      exit_err_q      <= exit_err_d;
      gate_open_q     <= gate_open_d;
    end
  end

  assign entry_ack     = entry_ack_q;
  assign entry_slot    = entry_slot_q;
  assign entry_reject  = entry_reject_q;
  assign exit_ack      = exit_ack_q;
  assign exit_err      = exit_err_q;
  assign exit_location = exit_location_q;
  assign occupancy     = occupancy_q;
  assign free_count    = free_count_q;
  assign gate_open     = gate_open_q;
  assign full          = (free_count_q == (IDX_W + 1)'(0));
  assign empty         = (free_count_q == SLOTS_CNT);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_parking_slot_manager.sv
// Bench for parking_slot_manager: random and directed traffic on an 8-slot lot
// checked against a slot-array model, plus a 6-slot lot for range and fill edges.
module tb_parking_slot_manager;

  localparam int NS  = 8;
  localparam int GC  = 4;
  localparam int NS2 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, entry_req, exit_req;
  logic [2:0]    exit_slot;
  logic          entry_ack, entry_reject, exit_ack, exit_err;
  logic [2:0]    entry_slot;
  logic [NS-1:0] exit_location, occupancy;
  logic [3:0]    free_count;
  logic          full, empty, gate_open, busy;

  parking_slot_manager #(.NUM_SLOTS(NS), .GATE_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .entry_ack(entry_ack), .entry_slot(entry_slot),
    .entry_reject(entry_reject), .exit_ack(exit_ack), .exit_err(exit_err),
    .exit_location(exit_location), .occupancy(occupancy), .free_count(free_count),
    .full(full), .empty(empty), .gate_open(gate_open), .busy(busy)
  );

  logic           rst2_n, entry_req2, exit_req2;
  logic [2:0]     exit_slot2, entry_slot2;
  logic           entry_ack2, entry_reject2, exit_ack2, exit_err2;
  logic [NS2-1:0] exit_location2, occupancy2;
  logic [3:0]     free_count2;
  logic           full2, empty2, gate_open2, busy2;

  parking_slot_manager #(.NUM_SLOTS(NS2), .GATE_CYCLES(2)) dut6 (
    .clk(clk), .rst_n(rst2_n), .entry_req(entry_req2), .exit_req(exit_req2),
    .exit_slot(exit_slot2), .entry_ack(entry_ack2), .entry_slot(entry_slot2),
    .entry_reject(entry_reject2), .exit_ack(exit_ack2), .exit_err(exit_err2),
    .exit_location(exit_location2), .occupancy(occupancy2), .free_count(free_count2),
    .full(full2), .empty(empty2), .gate_open(gate_open2), .busy(busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a slot array, a remaining-gate-time counter and the last pulses.
  bit m_occ [NS];
  int m_gate_left;
  int m_entry_slot;
  int m_exit_loc;
  bit m_entry_ack, m_entry_reject, m_exit_ack, m_exit_err;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
    m_gate_left = 0; m_entry_slot = 0; m_exit_loc = 0;
    m_entry_ack = 1'b0; m_entry_reject = 1'b0; m_exit_ack = 1'b0; m_exit_err = 1'b0;
  endtask

  task automatic model_edge(input bit er, input bit xr, input int xs);
    int f;
    m_entry_ack = 1'b0; m_entry_reject = 1'b0; m_exit_ack = 1'b0; m_exit_err = 1'b0;
    if (m_gate_left > 0) begin
      m_gate_left--;
    end else if (xr) begin
      if (xs < NS && m_occ[xs]) begin
        m_occ[xs] = 1'b0; m_exit_ack = 1'b1; m_exit_loc = 1 << xs; m_gate_left = GC;
      end else begin
        m_exit_err = 1'b1;
      end
    end else if (er) begin
      f = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) f = i;
      if (f >= 0) begin
        m_occ[f] = 1'b1; m_entry_slot = f; m_entry_ack = 1'b1; m_gate_left = GC;
      end else begin
        m_entry_reject = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [NS-1:0] occ_v;
    int nfree;
    nfree = 0;
    for (int i = 0; i < NS; i++) begin
      occ_v[i] = m_occ[i];
      if (!m_occ[i]) nfree++;
    end
    check("entry_ack",     32'(entry_ack),     32'(m_entry_ack));
    check("entry_slot",    32'(entry_slot),    32'(m_entry_slot));
    check("entry_reject",  32'(entry_reject),  32'(m_entry_reject));
    check("exit_ack",      32'(exit_ack),      32'(m_exit_ack));
    check("exit_err",      32'(exit_err),      32'(m_exit_err));
    check("exit_location", 32'(exit_location), 32'(m_exit_loc));
    check("occupancy",     32'(occupancy),     32'(occ_v));
    check("free_count",    32'(free_count),    32'(nfree));
    check("full",          32'(full),          32'(nfree == 0));
    check("empty",         32'(empty),         32'(nfree == NS));
    check("gate_open",     32'(gate_open),     32'(m_gate_left > 0));
    check("busy",          32'(busy),          32'(m_gate_left > 0));
  endtask

  // Called on a falling edge: check, drive inputs for the next rising edge, advance the model.
  task automatic cycle(input bit er, input bit xr, input int xs);
    compare_all();
    entry_req = er; exit_req = xr; exit_slot = 3'(xs);
    model_edge(er, xr, xs);
    @(negedge clk);
  endtask

  initial begin
    int pe, px;
    rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 3'd0;
    rst2_n = 1'b0; entry_req2 = 1'b0; exit_req2 = 1'b0; exit_slot2 = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1; rst2_n = 1'b1;

    // Fill from empty with a held request: 8 grants 5 cycles apart, then rejects.
    for (int i = 0; i < 45; i++) cycle(1'b1, 1'b0, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_free", 32'(free_count), 32'd0);
    // Release slot 3 from a full lot, then an entry reuses it.
    cycle(1'b0, 1'b1, 3);
    check("rel_loc", 32'(exit_location), 32'h08);
    check("rel_occ", 32'(occupancy), 32'hF7);
    // Entry pulse while the exit gate is open must be ignored.
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 0);
    check("reuse_slot", 32'(entry_slot), 32'd3);
    // Invalid exit on a free slot, and both requests at once.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, i);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 5);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 0);

    // Random traffic in phases biased toward filling, draining and mixing.
    for (int ph = 0; ph < 4; ph++) begin
      pe = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      px = (ph == 0) ? 15 : (ph == 1) ? 70 : 40;
      for (int i = 0; i < 300; i++)
        cycle($urandom_range(0, 99) < pe, $urandom_range(0, 99) < px, $urandom_range(0, NS - 1));
    end

    // Asynchronous reset in the middle of an open gate.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 0);
    for (int i = 0; i < NS; i++) cycle(1'b0, 1'b1, i);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    check("pre_rst_gate", 32'(gate_open), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gate", 32'(gate_open), 32'd0);
    check("arst_occ",  32'(occupancy), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_free", 32'(free_count), 32'd8);
    check("arst_empty", 32'(empty), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // Six-slot lot, two-cycle gate: out-of-range exit, fill and reject.
    exit_req2 = 1'b1; exit_slot2 = 3'd7;
    @(negedge clk);
    check("n6_err_range", 32'(exit_err2), 32'd1);
    check("n6_err_gate", 32'(gate_open2), 32'd0);
    exit_req2 = 1'b0; entry_req2 = 1'b1;
    repeat (18) @(negedge clk);
    check("n6_full", 32'(full2), 32'd1);
    check("n6_free", 32'(free_count2), 32'd0);
    check("n6_occ", 32'(occupancy2), 32'h3F);
    check("n6_slot", 32'(entry_slot2), 32'd5);
    @(negedge clk);
    check("n6_reject", 32'(entry_reject2), 32'd1);
    entry_req2 = 1'b0; exit_req2 = 1'b1; exit_slot2 = 3'd6;
    @(negedge clk);
    check("n6_err6", 32'(exit_err2), 32'd1);
    exit_slot2 = 3'd2;
    @(negedge clk);
    check("n6_exit_ack", 32'(exit_ack2), 32'd1);
    check("n6_exit_loc", 32'(exit_location2), 32'h04);
    exit_req2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
